// File: rtl/div_unit_pkg.sv
// Shared definitions for the multicycle signed divider: state encoding and default width.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

endpackage : div_unit_pkg

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, set the new quotient bit.
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] r_full;
    logic           ge;
    logic           unused_top;

    // R < D before the shift, so the shifted remainder needs one extra bit.
    assign r_sh   = {r_i, q_i[WIDTH-1]};
    assign ge     = (r_sh >= {1'b0, d_i});
    assign r_full = ge ? (r_sh - {1'b0, d_i}) : r_sh;

    // The top bit is always zero here: the kept remainder is below D.
    assign r_o        = r_full[WIDTH-1:0];
    assign unused_top = r_full[WIDTH];
    assign q_o        = {q_i[WIDTH-2:0], ge};

endmodule : div_unit_step

// File: rtl/div_unit.sv
// Multicycle signed divider (restoring, one quotient bit per clock); quotient on lo, remainder on hi.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] r_nx, q_nx;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (r_nx),
        .q_o (q_nx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Magnitudes are taken unsigned, so the most negative value maps to itself.
                    dz_d   = 1'b0;
                    r_d    = '0;
                    q_d    = dividend[WIDTH-1] ? -dividend : dividend;
                    d_d    = divisor[WIDTH-1]  ? -divisor  : divisor;
                    qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d = dividend[WIDTH-1];
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                r_d   = r_nx;
                q_d   = q_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    lo_d    = qneg_q ? -q_nx : q_nx;
                    hi_d    = rneg_q ? -r_nx : r_nx;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed results, divide-by-zero and reset abort.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the IDLE cycle after done,
    // so consecutive calls exercise back-to-back requests.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input int exp_lat, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input logic exp_dz);
        int n;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".dz_acc"}, 32'(div_zero), 32'(b == 32'd0));
        n = 0;
        while (!done && n < 100) begin
            // A start pulse while busy must be ignored.
            start = (n == 5);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ".lat"}, 32'(n), 32'(exp_lat));
        chk({tag, ".lo"}, lo, exp_lo);
        chk({tag, ".hi"}, hi, exp_hi);
        chk({tag, ".dz"}, 32'(div_zero), 32'(exp_dz));
        @(negedge clk);
        chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        int n_done;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.flags", {29'd0, busy, done, div_zero}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_div("p100_7",   32'd100,        32'd7,          32, 32'd14,         32'd2,          1'b0);
        run_div("div0",     32'd5,          32'd0,          0,  32'd14,         32'd2,          1'b1);
        run_div("n100_7",   32'hFFFF_FF9C,  32'd7,          32, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0);
        run_div("p100_n7",  32'd100,        32'hFFFF_FFF9,  32, 32'hFFFF_FFF2,  32'd2,          1'b0);
        run_div("n100_n7",  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32, 32'd14,         32'hFFFF_FFFE,  1'b0);
        run_div("wrap",     32'h8000_0000,  32'hFFFF_FFFF,  32, 32'h8000_0000,  32'd0,          1'b0);
        run_div("p7_100",   32'd7,          32'd100,        32, 32'd0,          32'd7,          1'b0);
        run_div("m1_min",   32'hFFFF_FFFF,  32'h8000_0000,  32, 32'd0,          32'hFFFF_FFFF,  1'b0);
        run_div("max_1",    32'h7FFF_FFFF,  32'd1,          32, 32'h7FFF_FFFF,  32'd0,          1'b0);

        // Abort a request with reset at its 10th RUN edge.
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            start    = (i == 4);
            dividend = 32'd77;
            divisor  = 32'd5;
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        chk("abort.busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort.flags", {29'd0, busy, done, div_zero}, 32'd0);
        chk("abort.hi", hi, 32'd0);
        chk("abort.lo", lo, 32'd0);
        reset  = 1'b1;
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort.no_done", 32'(n_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_div_unit
